// File: rtl/obstacle_pkg.sv
// Shared encodings for the obstacle lane engine: slot types, run state, rate threshold.
package obstacle_pkg;

  // Slot contents; any nonzero value other than OBS_HIGH behaves as low
  localparam int OBS_EMPTY = 0;
  localparam int OBS_LOW   = 1;
  localparam int OBS_HIGH  = 2;

  // Level from which a spawn no longer needs the random rate gate
  localparam int LEVEL_RATE_THR = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/obstacle_lane.sv
// Obstacle shift register: moves the lane one slot toward the dino per shift and
// inserts a new obstacle at the top slot only when the guard window is clear.
module obstacle_lane
  import obstacle_pkg::*;
#(
  parameter int LANE_LEN = 16,
  parameter int TYPE_W   = 2,
  parameter int GAP_W    = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       clear,
  input  logic                       shift,
  input  logic [TYPE_W-1:0]          spawn_type,
  input  logic [GAP_W-1:0]           gap,
  output logic [LANE_LEN*TYPE_W-1:0] map
);

  logic [LANE_LEN*TYPE_W-1:0] map_reg;
  logic [LANE_LEN*TYPE_W-1:0] map_next;
  logic [LANE_LEN-1:0]        slot_busy;
  logic                       window_clear;
  logic [TYPE_W-1:0]          top_next;

  // A slot blocks spawning when it is occupied and lies in the top 'gap' slots
  genvar gi;
  generate
    for (gi = 0; gi < LANE_LEN; gi++) begin : g_guard
      assign slot_busy[gi] = (map_reg[TYPE_W*gi +: TYPE_W] != '0) &&
                             ((gi + int'(gap)) >= LANE_LEN);
    end
  endgenerate

  assign window_clear = ~|slot_busy;
  assign top_next     = window_clear ? spawn_type : TYPE_W'(OBS_EMPTY);
  assign map_next     = {top_next, map_reg[LANE_LEN*TYPE_W-1:TYPE_W]};

  // Lane storage: clear wins over shift
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      map_reg <= '0;
    end else if (shift) begin
      map_reg <= map_next;
    end
  end

  assign map = map_reg;

endmodule

// File: rtl/obstacle_lane_engine.sv
// Runner game core: run-state FSM, dino posture, collision, score and level,
// with the obstacle lane itself delegated to obstacle_lane.
module obstacle_lane_engine
  import obstacle_pkg::*;
#(
  parameter int LANE_LEN    = 16,
  parameter int TYPE_W      = 2,
  parameter int JUMP_TICKS  = 2,
  parameter int GAP_BASE    = 11,
  parameter int GAP_MIN     = 5,
  parameter int SCORE_W     = 32,
  parameter int SCORE_MAX   = 100000000,
  parameter int LEVEL_SHIFT = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       shift_enable,
  input  logic                       jump_trigger,
  input  logic                       duck,
  input  logic                       start_game,
  input  logic                       force_game_over,
  input  logic [15:0]                rand_val,
  output logic                       game_over,
  output logic                       running,
  output logic                       dino_on_ground,
  output logic                       dino_ducking,
  output logic [SCORE_W-1:0]         score,
  output logic [3:0]                 level,
  output logic [LANE_LEN*TYPE_W-1:0] obstacle_map_flat
);

  localparam int GAP_W = 8;
  localparam int CNT_W = $clog2(JUMP_TICKS + 2);

  state_t                     state_reg, state_next;
  logic                       on_ground_reg, ducking_reg, jump_latch_reg;
  logic [CNT_W-1:0]           jump_cnt_reg;
  logic [SCORE_W-1:0]         score_reg;
  logic [3:0]                 level_reg;
  logic [LANE_LEN*TYPE_W-1:0] map;

  logic                       tick, takeoff, jump_set;
  logic [TYPE_W-1:0]          slot0;
  logic                       slot_high, slot_low, collision;
  logic [SCORE_W-1:0]         score_inc, level_raw;
  logic                       score_hit;
  logic [3:0]                 level_next;
  logic [GAP_W-1:0]           gap;
  logic                       rate_ok;
  logic [TYPE_W-1:0]          spawn_type;
  logic                       unused_rand;

  // A tick is processed only in RUN and only when no control input overrides it
  assign tick      = (state_reg == RUN) && shift_enable && !start_game && !force_game_over;
  assign takeoff   = jump_latch_reg && on_ground_reg;
  assign jump_set  = (state_reg == RUN) && jump_trigger && on_ground_reg;

  assign slot0     = map[TYPE_W-1:0];
  assign slot_high = (slot0 == TYPE_W'(OBS_HIGH));
  assign slot_low  = (slot0 != TYPE_W'(OBS_EMPTY)) && !slot_high;
  assign collision = on_ground_reg && (slot_low || (slot_high && !ducking_reg));

  assign score_inc  = score_reg + SCORE_W'(1);
  assign score_hit  = (score_inc == SCORE_W'(SCORE_MAX));
  assign level_raw  = score_inc >> LEVEL_SHIFT;
  assign level_next = (level_raw > SCORE_W'(15)) ? 4'd15 : level_raw[3:0];

  assign rate_ok    = (level_reg >= 4'(LEVEL_RATE_THR)) || (rand_val[1:0] != 2'b11);
  assign spawn_type = rate_ok ? (rand_val[2] ? TYPE_W'(OBS_LOW) : TYPE_W'(OBS_HIGH))
                              : TYPE_W'(OBS_EMPTY);
  assign unused_rand = ^rand_val[15:3];

  // Guard window shrinks by one slot per level down to its floor
  always_comb begin
    gap = GAP_W'(GAP_MIN);
    if (int'(level_reg) + GAP_MIN < GAP_BASE) begin
      gap = GAP_W'(GAP_BASE - int'(level_reg));
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: start beats force, force beats the tick
  always_comb begin
    state_next = state_reg;
    if (start_game) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (force_game_over) begin
            state_next = OVER;
          end else if (shift_enable && (collision || score_hit)) begin
            state_next = OVER;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // FSM outputs decoded from the state register
  always_comb begin
    game_over = (state_reg == OVER);
    running   = (state_reg == RUN);
  end

  // Posture, jump latch, score and level; frozen outside processed ticks
  always_ff @(posedge CLK) begin
    if (RST || start_game) begin
      on_ground_reg  <= 1'b1;
      ducking_reg    <= 1'b0;
      jump_latch_reg <= 1'b0;
      jump_cnt_reg   <= '0;
      score_reg      <= '0;
      level_reg      <= '0;
    end else begin
      jump_latch_reg <= jump_set || (jump_latch_reg && !(tick && takeoff));
      if (tick) begin
        score_reg <= score_inc;
        level_reg <= level_next;
        if (takeoff) begin
          on_ground_reg <= 1'b0;
          jump_cnt_reg  <= CNT_W'(JUMP_TICKS);
          ducking_reg   <= 1'b0;
        end else if (!on_ground_reg) begin
          if (jump_cnt_reg != '0) begin
            jump_cnt_reg <= jump_cnt_reg - CNT_W'(1);
          end else begin
            on_ground_reg <= 1'b1;
          end
        end else begin
          ducking_reg <= duck;
        end
      end
    end
  end

  obstacle_lane #(
    .LANE_LEN (LANE_LEN),
    .TYPE_W   (TYPE_W),
    .GAP_W    (GAP_W)
  ) u_lane (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (start_game),
    .shift      (tick),
    .spawn_type (spawn_type),
    .gap        (gap),
    .map        (map)
  );

  assign dino_on_ground    = on_ground_reg;
  assign dino_ducking      = ducking_reg;
  assign score             = score_reg;
  assign level             = level_reg;
  assign obstacle_map_flat = map;

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Bench for obstacle_lane_engine: two instances (default and SCORE_MAX=20) driven
// in lockstep, checked every cycle against a slot-array model plus literal pins.
module tb_obstacle_lane_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        shift_enable = 1'b0;
  logic        jump_trigger = 1'b0;
  logic        duck = 1'b0;
  logic        start_game = 1'b0;
  logic        force_game_over = 1'b0;
  logic [15:0] rand_val = 16'h0;

  logic        go_a, run_a, og_a, dk_a, go_b, run_b, og_b, dk_b;
  logic [31:0] score_a, score_b, map_a, map_b;
  logic [3:0]  level_a, level_b;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  bit duck_hold = 0;

  // model state per instance: 0 = default, 1 = SCORE_MAX 20
  int m_st[2];
  int m_lane[2][16];
  int m_score[2];
  int m_level[2];
  bit m_og[2];
  bit m_dk[2];
  bit m_latch[2];
  int m_cnt[2];

  always #5 CLK = ~CLK;

  obstacle_lane_engine dut_a (
    .CLK(CLK), .RST(RST), .shift_enable(shift_enable), .jump_trigger(jump_trigger),
    .duck(duck), .start_game(start_game), .force_game_over(force_game_over),
    .rand_val(rand_val), .game_over(go_a), .running(run_a), .dino_on_ground(og_a),
    .dino_ducking(dk_a), .score(score_a), .level(level_a), .obstacle_map_flat(map_a)
  );

  obstacle_lane_engine #(.SCORE_MAX(20)) dut_b (
    .CLK(CLK), .RST(RST), .shift_enable(shift_enable), .jump_trigger(jump_trigger),
    .duck(duck), .start_game(start_game), .force_game_over(force_game_over),
    .rand_val(rand_val), .game_over(go_b), .running(run_b), .dino_on_ground(og_b),
    .dino_ducking(dk_b), .score(score_b), .level(level_b), .obstacle_map_flat(map_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance model k by one clock edge using the inputs currently applied
  task automatic model_step(input int k, input int smax);
    int  s0, gap;
    bit  collide, empty, rate, takeoff, newset;
    if (RST || start_game) begin
      for (int i = 0; i < 16; i++) m_lane[k][i] = 0;
      m_score[k] = 0; m_level[k] = 0; m_og[k] = 1; m_dk[k] = 0;
      m_latch[k] = 0; m_cnt[k] = 0;
      m_st[k] = RST ? 0 : 1;
      return;
    end
    if (m_st[k] != 1) return;
    newset = jump_trigger && m_og[k];
    if (force_game_over) begin
      m_st[k] = 2;
      m_latch[k] = m_latch[k] || newset;
      return;
    end
    if (!shift_enable) begin
      m_latch[k] = m_latch[k] || newset;
      return;
    end
    s0 = m_lane[k][0];
    collide = m_og[k] && ((s0 != 0 && s0 != 2) || (s0 == 2 && !m_dk[k]));
    gap = 11 - m_level[k];
    if (gap < 5) gap = 5;
    empty = 1;
    for (int i = 16 - gap; i < 16; i++) if (m_lane[k][i] != 0) empty = 0;
    rate = (m_level[k] >= 4) || (rand_val[1:0] != 2'b11);
    for (int i = 0; i < 15; i++) m_lane[k][i] = m_lane[k][i+1];
    m_lane[k][15] = (empty && rate) ? (rand_val[2] ? 1 : 2) : 0;
    takeoff = m_latch[k] && m_og[k];
    if (takeoff) begin
      m_og[k] = 0; m_cnt[k] = 2; m_dk[k] = 0;
    end else if (!m_og[k]) begin
      if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
      else m_og[k] = 1;
    end else begin
      m_dk[k] = duck;
    end
    m_latch[k] = newset || (m_latch[k] && !takeoff);
    m_score[k] = m_score[k] + 1;
    m_level[k] = (m_score[k] / 64 > 15) ? 15 : m_score[k] / 64;
    if (collide || m_score[k] == smax) m_st[k] = 2;
  endtask

  function automatic logic [31:0] model_map(input int k);
    logic [31:0] v;
    int t;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      t = m_lane[k][i];
      v[2*i +: 2] = t[1:0];
    end
    return v;
  endfunction

  task automatic cmp_dut(input int k, input logic go, input logic run, input logic og,
                         input logic dk, input logic [31:0] sc, input logic [3:0] lv,
                         input logic [31:0] mp);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".game_over"}, 64'(go), 64'(m_st[k] == 2));
    chk({p, ".running"}, 64'(run), 64'(m_st[k] == 1));
    chk({p, ".dino_on_ground"}, 64'(og), 64'(m_og[k]));
    chk({p, ".dino_ducking"}, 64'(dk), 64'(m_dk[k]));
    chk({p, ".score"}, 64'(sc), 64'(m_score[k]));
    chk({p, ".level"}, 64'(lv), 64'(m_level[k]));
    chk({p, ".map"}, 64'(mp), 64'(model_map(k)));
  endtask

  // Per-cycle comparison of both instances against the model, mid-cycle
  always @(negedge CLK) begin
    if (cmp_en) begin
      cmp_dut(0, go_a, run_a, og_a, dk_a, score_a, level_a, map_a);
      cmp_dut(1, go_b, run_b, og_b, dk_b, score_b, level_b, map_b);
    end
  end

  task automatic cyc(input logic r, input logic st, input logic fo, input logic se,
                     input logic jt, input logic dk, input logic [15:0] rv);
    RST = r; start_game = st; force_game_over = fo; shift_enable = se;
    jump_trigger = jt; duck = dk; rand_val = rv;
    @(posedge CLK);
    model_step(0, 100000000);
    model_step(1, 20);
    #1;
  endtask

  task automatic tk(input logic [15:0] rv);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, duck_hold, rv);
  endtask

  task automatic begin_run();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, duck_hold, 16'h3);
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cmp_en = 1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset.game_over", 64'(go_a), 64'd0);
    chk("reset.running", 64'(run_a), 64'd0);
    chk("reset.map", 64'(map_a), 64'd0);
    chk("reset.score", 64'(score_a), 64'd0);
    chk("reset.level", 64'(level_a), 64'd0);
    chk("reset.on_ground", 64'(og_a), 64'd1);

    // spawn of a high obstacle, then guard window blocks further spawns
    begin_run();
    tk(16'h0000);
    chk("spawn.top", 64'(map_a[31:30]), 64'd2);
    for (int j = 1; j <= 10; j++) begin
      tk(16'($urandom));
      chk("spawn.guard_top", 64'(map_a[31:30]), 64'd0);
    end

    // low obstacle reaches the dino and collides on the 16th tick
    begin_run();
    tk(16'h0004);
    for (int j = 1; j <= 16; j++) begin
      tk(16'h0003);
      if (j == 15) begin
        chk("low.slot0", 64'(map_a[1:0]), 64'd1);
        chk("low.not_yet_over", 64'(go_a), 64'd0);
      end
    end
    chk("low.game_over", 64'(go_a), 64'd1);
    chk("low.score", 64'(score_a), 64'd17);
    for (int j = 0; j < 3; j++) tk(16'h0003);
    chk("low.score_frozen", 64'(score_a), 64'd17);

    // jump over a low obstacle
    begin_run();
    tk(16'h0004);
    for (int j = 0; j < 14; j++) tk(16'h0003);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3);
    for (int j = 1; j <= 16; j++) begin
      tk(16'h0003);
      if (j <= 4) chk("jump.on_ground", 64'(og_a), 64'(j == 4));
    end
    chk("jump.no_over", 64'(go_a), 64'd0);
    chk("jump.score", 64'(score_a), 64'd31);

    // duck under a high obstacle, then the same without ducking
    duck_hold = 1;
    begin_run();
    tk(16'h0000);
    for (int j = 0; j < 16; j++) tk(16'h0003);
    chk("duck.no_over", 64'(go_a), 64'd0);
    chk("duck.ducking", 64'(dk_a), 64'd1);
    duck_hold = 0;
    begin_run();
    tk(16'h0000);
    for (int j = 1; j <= 16; j++) begin
      tk(16'h0003);
      if (j == 15) chk("noduck.not_yet_over", 64'(go_a), 64'd0);
    end
    chk("noduck.game_over", 64'(go_a), 64'd1);

    // score limit on the SCORE_MAX=20 instance, then forced end with a tick
    begin_run();
    for (int j = 1; j <= 20; j++) begin
      tk(16'h0003);
      if (j == 19) chk("limit.not_yet_over", 64'(go_b), 64'd0);
    end
    chk("limit.score", 64'(score_b), 64'd20);
    chk("limit.game_over", 64'(go_b), 64'd1);
    chk("limit.default_running", 64'(run_a), 64'd1);
    begin_run();
    for (int j = 0; j < 5; j++) tk(16'h0003);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3);
    chk("force.game_over", 64'(go_a), 64'd1);
    chk("force.score", 64'(score_a), 64'd5);

    // long run with only high obstacles while ducking: levels climb to 15
    duck_hold = 1;
    begin_run();
    for (int j = 0; j < 1000; j++) tk(16'($urandom) & 16'hfffb);
    chk("level.max", 64'(level_a), 64'd15);
    chk("level.running", 64'(run_a), 64'd1);
    duck_hold = 0;

    // fully random play with restarts
    for (int j = 0; j < 3000; j++) begin
      logic r, st, fo, se, jt, dk;
      r  = ($urandom_range(0, 999) == 0);
      st = (!run_a && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
      fo = ($urandom_range(0, 199) == 0);
      se = ($urandom_range(0, 9) < 6);
      jt = ($urandom_range(0, 99) < 15);
      dk = ($urandom_range(0, 9) < 3);
      cyc(r, st, fo, se, jt, dk, 16'($urandom));
    end

    cmp_en = 0;
    @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_lane_engine.md
# obstacle_lane_engine

Parametrised successor to the single-lane runner obstacle manager. It adds a run-state FSM, configurable lane length, type width and jump length, a duck posture for high obstacles, and level-based difficulty that shortens spawn spacing and raises spawn rate. It sits between the game tick divider / LFSR and the display renderer, and it owns obstacle motion, dino posture, collision, score and level.

## Interface
- LANE_LEN, 16: lane slots; slot 0 is the dino column. Range 8..64.
- TYPE_W, 2: bits per slot; 0 = empty, 1 = low, 2 = high, any other nonzero value = low.
- JUMP_TICKS, 2: airborne ticks after the take-off tick.
- GAP_BASE, 11: spawn-guard window at level 0. Must be < LANE_LEN.
- GAP_MIN, 5: floor of the spawn-guard window.
- SCORE_W, 32: score width.
- SCORE_MAX, 100000000: score at which the game ends.
- LEVEL_SHIFT, 6: level rises every 2^LEVEL_SHIFT ticks.
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- shift_enable  in  1  one-cycle game tick.
- jump_trigger  in  1  jump request pulse.
- duck  in  1  duck request, level-sensitive.
- start_game  in  1  clear all state and enter RUN.
- force_game_over  in  1  end the game immediately.
- rand_val  in  16  random word from the LFSR.
- game_over  out  1  high when state = OVER.
- running  out  1  high when state = RUN.
- dino_on_ground  out  1  low while airborne.
- dino_ducking  out  1  duck posture latched at the last tick.
- score  out  SCORE_W  ticks survived.
- level  out  4  difficulty level, 0..15.
- obstacle_map_flat  out  LANE_LEN*TYPE_W  slot i occupies bits [TYPE_W*i +: TYPE_W].

## Operation
- FSM states: IDLE, RUN, OVER.
  - Reset enters IDLE.
  - start_game moves any state to RUN.
  - force_game_over in RUN moves to OVER.
  - A collision or score reaching SCORE_MAX in RUN moves to OVER.
- Reset values: map all 0, score 0, level 0, dino_on_ground 1, dino_ducking 0, game_over 0, running 0, jump latch 0, jump counter 0.
- start_game applies the same clears as reset but enters RUN.
- Priority per cycle: RST > start_game > force_game_over > tick processing. A forced end discards the tick in the same cycle.
- Jump latch:
  - Set when state = RUN, jump_trigger = 1 and dino_on_ground = 1.
  - Held until consumed by a tick.
  - jump_trigger is ignored in IDLE and OVER.
- Tick (RUN and shift_enable) evaluates from pre-edge values:
  - Collision: slot 0 low and on ground; or slot 0 high, on ground and not ducking → OVER. All other tick updates still apply.
  - Shift: slot i ← slot i+1 for i < LANE_LEN-1.
  - Spawn: gap = max(GAP_MIN, GAP_BASE - level). Spawn when pre-shift slots LANE_LEN-gap..LANE_LEN-1 are all empty and the rate condition holds.
    - Rate condition: rand_val[1:0] != 3 while level < 4; always at level ≥ 4.
    - Spawned type: rand_val[2] ? 1 : 2. With no spawn, the top slot gets 0.
  - Posture:
    - Latch set and on ground → take-off: on_ground 0, counter JUMP_TICKS, latch cleared, ducking 0.
    - Airborne with counter > 0 → counter decrements.
    - Airborne with counter = 0 → lands, on_ground 1.
    - On ground with no take-off → dino_ducking ← duck.
  - Score: score + 1. If the result equals SCORE_MAX → OVER. Score never exceeds SCORE_MAX.
  - Level: min(15, (score+1) >> LEVEL_SHIFT).
- OVER freezes all outputs until start_game or RST. force_game_over in IDLE or OVER is ignored.

## Timing
- All outputs are registered and update on the CLK edge that samples the tick or control input. No combinational input-to-output path.
- Take-off appears at the first tick after the request; the dino stays airborne for JUMP_TICKS+1 ticks.
- A request raised in the same cycle as a tick is latched, and takes effect at the following tick.
- An obstacle spawned at tick t sits in slot 0 after tick t+LANE_LEN-1, and collides on tick t+LANE_LEN.
- Simultaneous collision and score reaching SCORE_MAX give a single transition to OVER; score still updates.

## Structure
- Package obstacle_pkg holds:
  - Type encodings OBS_EMPTY, OBS_LOW and OBS_HIGH.
  - The state enum {IDLE, RUN, OVER}.
  - The level rate threshold, 4.
- One sub-module, obstacle_lane: parametrised shift register that performs the guard-window check and spawn insertion. It has ports CLK, RST, clear, shift, spawn_type, gap and map. The FSM, posture, score and level logic live in the top.

## Test plan
All scenarios use default parameters.
- Reset: RST high for 2 cycles → game_over 0, running 0, map 0, score 0, level 0, dino_on_ground 1.
- Spawn: start_game, then a tick with rand_val = 16'h0000 → obstacle_map_flat[31:30] = 2'b10. The next 10 ticks with any rand_val produce no spawn.
- Low obstacle collision: type 1 spawned via rand_val = 16'h0004, no jump → game_over 1 at the 16th tick after the spawn. Score is frozen at that value.
- Jump: take-off pulse, then 16 ticks → dino_on_ground reads 0,0,0,1 across the first 4 ticks. An obstacle in slot 0 during ticks 1–3 gives no game over.
- Duck: a high obstacle (rand_val = 16'h0000) reaches slot 0 while duck is held → no collision. The same case with duck = 0 → game_over 1.
- Score limit and force: with SCORE_MAX = 20, the 20th tick gives score 20 and game_over 1. A new run with force_game_over coinciding with a tick → OVER, and score is unchanged.
